// File: rtl/alu_exec_unit_pkg.sv
// Purpose: encodings shared by the ALU control decoder and alu_exec_unit.
//   ALU_* : 3-bit ALU control codes.
//   ST_*  : alu_exec_unit FSM state encoding.
package alu_exec_unit_pkg;

  localparam int unsigned ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 3'b011;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Purpose: iterative shift-add multiplier datapath (acc/mcand/mplier/cnt).
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : load operands, clear acc/cnt
//   step_i         : perform one shift-add iteration this edge
//   mcand_i        : multiplicand
//   mplier_i       : multiplier
//   done_c_o       : this step is the final iteration (combinational)
//   product_c_o    : accumulator value after this step (combinational)
// Optional: MUL_EARLY_TERM_EN ends the operation once the remaining
// multiplier bits are all zero.
module shift_add_mul #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic              done_c_o,
  output logic [DATA_W-1:0] product_c_o
);

  logic [DATA_W-1:0] acc_q,    acc_d;
  logic [DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [DATA_W-1:0] acc_step;
  logic              last_iter;

  // Accumulator after conditionally adding the current multiplicand.
  assign acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product_c_o = acc_step;

`ifdef MUL_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after this shift.
  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1)) || ((mplier_q >> 1) == '0);
`else
  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));
`endif

  assign done_c_o = step_i && last_iter;

  // Next-state for the datapath registers.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Purpose: EX-stage execution unit. AND/OR/ADD/SUB complete in one cycle;
// MUL runs on the iterative shift_add_mul datapath while busy_o stalls ID/EX.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   valid_i        : issue strobe, accepted when busy_o==0
//   ALUCtrl_i      : ALU control code
//   data1_i/data2_i: operands (multiplicand/multiplier for MUL)
//   result_o       : registered result, held between completions
//   zero_o         : registered result==0 flag
//   valid_o        : one-cycle completion pulse
//   busy_o         : MUL in progress
// Optional: MUL_EARLY_TERM_EN shortens MUL latency (see shift_add_mul).
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [ALU_CTRL_W-1:0] ALUCtrl_i,
  input  logic [DATA_W-1:0]     data1_i,
  input  logic [DATA_W-1:0]     data2_i,
  output logic [DATA_W-1:0]     result_o,
  output logic                  zero_o,
  output logic                  valid_o,
  output logic                  busy_o
);

  logic [0:0]        state_q,  state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q,   zero_d;
  logic              valid_q,  valid_d;
  logic              mul_start;
  logic              mul_done_c;
  logic [DATA_W-1:0] mul_product_c;

  // Single-cycle operations; undefined codes yield zero.
  function automatic logic [DATA_W-1:0] single_op(
    input logic [ALU_CTRL_W-1:0] ctrl,
    input logic [DATA_W-1:0]     a,
    input logic [DATA_W-1:0]     b
  );
    case (ctrl)
      ALU_AND: single_op = a & b;
      ALU_OR:  single_op = a | b;
      ALU_ADD: single_op = a + b;
      ALU_SUB: single_op = a - b;
      default: single_op = '0;
    endcase
  endfunction

  shift_add_mul #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_mul (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (mul_start),
    .step_i      (state_q == ST_MUL),
    .mcand_i     (data1_i),
    .mplier_i    (data2_i),
    .done_c_o    (mul_done_c),
    .product_c_o (mul_product_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (ALUCtrl_i == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            result_d = single_op(ALUCtrl_i, data1_i, data2_i);
            zero_d   = (result_d == '0);
            valid_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done_c) begin
          result_d = mul_product_c;
          zero_d   = (mul_product_c == '0);
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign valid_o  = valid_q;
  assign busy_o   = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a result scoreboard.
module tb_alu_exec_unit;

  localparam int unsigned DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic [2:0]        ALUCtrl_i;
  logic [DATA_W-1:0] data1_i;
  logic [DATA_W-1:0] data2_i;
  logic [DATA_W-1:0] result_o;
  logic              zero_o;
  logic              valid_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;

  // Expected {zero, result} for each completion, in issue order.
  logic [DATA_W:0] exp_q[$];

  alu_exec_unit #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int mul_lat(input logic [DATA_W-1:0] b);
    int hi;
    hi = -1;
`ifdef MUL_EARLY_TERM_EN
    for (int i = 0; i < int'(DATA_W); i++) if (b[i]) hi = i;
    return (hi < 0) ? 2 : hi + 2;
`else
    hi = int'(DATA_W) + 1;
    return hi;
`endif
  endfunction

  task automatic issue(input logic [2:0] c, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] r);
    valid_i   = 1'b1;
    ALUCtrl_i = c;
    data1_i   = a;
    data2_i   = b;
    exp_q.push_back({(r == '0), r});
  endtask

  // Called in cycle T+1 of an accepted MUL; ends in the completion cycle.
  task automatic mul_wait(input string tag, input int lat);
    for (int k = 1; k < lat; k++) begin
      chk({tag, "_busy"}, 64'(busy_o), 64'd1);
      chk({tag, "_novalid"}, 64'(valid_o), 64'd0);
      tick();
    end
    chk({tag, "_done_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done_valid"}, 64'(valid_o), 64'd1);
  endtask

  // Scoreboard: every completion pops and compares one expected entry.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 64'(result_o), 64'hDEAD_BEEF_0BAD_F00D);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        chk("sb_result", 64'(result_o), 64'(e[DATA_W-1:0]));
        chk("sb_zero", 64'(zero_o), 64'(e[DATA_W]));
      end
    end
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ALUCtrl_i = 3'b000; data1_i = '0; data2_i = '0;
    tick(); tick();
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_zero", 64'(zero_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // ADD wrap into sign bit
    issue(3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    tick();
    valid_i = 1'b0;
    chk("add_valid", 64'(valid_o), 64'd1);
    tick();
    chk("add_valid_drop", 64'(valid_o), 64'd0);
    chk("add_hold", 64'(result_o), 64'h8000_0000);

    // SUB then back-to-back AND
    issue(3'b110, 32'd5, 32'd5, 32'd0);
    tick();
    chk("sub_valid", 64'(valid_o), 64'd1);
    issue(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    tick();
    chk("and_valid", 64'(valid_o), 64'd1);
    issue(3'b001, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0);
    tick();
    valid_i = 1'b0;
    chk("or_valid", 64'(valid_o), 64'd1);
    tick();
    chk("idle_valid", 64'(valid_o), 64'd0);

    // MUL 7*3
    issue(3'b011, 32'd7, 32'd3, 32'd21);
    tick();
    valid_i = 1'b0;
    mul_wait("mul7x3", mul_lat(32'd3));
    tick();
    chk("mul7x3_after", 64'(valid_o), 64'd0);

    // MUL by zero
    issue(3'b011, 32'h1234, 32'd0, 32'd0);
    tick();
    valid_i = 1'b0;
    mul_wait("mulx0", mul_lat(32'd0));
    tick();

    // MUL all-ones with ADD held during busy
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    tick();
    valid_i = 1'b1; ALUCtrl_i = 3'b010; data1_i = 32'd10; data2_i = 32'd20;
    mul_wait("mulff", mul_lat(32'hFFFF_FFFF));
    exp_q.push_back({1'b0, 32'd30});
    tick();
    valid_i = 1'b0;
    chk("held_add_valid", 64'(valid_o), 64'd1);
    chk("held_add_busy", 64'(busy_o), 64'd0);
    tick();
    chk("held_add_once", 64'(valid_o), 64'd0);

    // Reset during MUL aborts with no completion
    valid_i = 1'b1; ALUCtrl_i = 3'b011; data1_i = 32'h1234_5678; data2_i = 32'h8000_0001;
    tick();
    valid_i = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    chk("abort_busy_pre", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    tick();
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_valid", 64'(valid_o), 64'd0);
    chk("abort_result", 64'(result_o), 64'd0);
    chk("abort_zero", 64'(zero_o), 64'd1);
    rst_i = 1'b0;
    begin
      int late;
      late = 0;
      for (int k = 0; k < 40; k++) begin
        if (valid_o || busy_o) late++;
        tick();
      end
      chk("abort_no_late", 64'(late), 64'd0);
    end

    // Undefined code
    issue(3'b101, 32'd3, 32'd4, 32'd0);
    tick();
    valid_i = 1'b0;
    chk("undef_valid", 64'(valid_o), 64'd1);
    tick();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
